// File: rtl/clock_meter_pkg.sv
// Shared types and default constants for the clock period meter.
package clock_meter_pkg;

  localparam int          DEF_CNT_W       = 32;
  localparam logic [31:0] DEF_TIMEOUT     = 32'd50_000_000;
  localparam int          DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEAS_HIGH,
    MEAS_LOW,
    DONE
  } state_t;

endpackage

// File: rtl/clock_period_meter_if.sv
// Request/result bundle of the clock period meter; slave is the meter side.
interface clock_period_meter_if #(
  parameter int CNT_W = clock_meter_pkg::DEF_CNT_W
);

  logic             istart;
  logic             obusy;
  logic             ovalid;
  logic             otimeout;
  logic [CNT_W-1:0] ohigh;
  logic [CNT_W-1:0] operiod;

  modport master (
    output istart,
    input  obusy, ovalid, otimeout, ohigh, operiod
  );

  modport slave (
    input  istart,
    output obusy, ovalid, otimeout, ohigh, operiod
  );

endinterface

// File: rtl/sig_sync_edge.sv
// Synchronises an asynchronous level into iclk and emits single-cycle rise/fall strobes.
module sig_sync_edge #(
  parameter int SYNC_STAGES = clock_meter_pkg::DEF_SYNC_STAGES
) (
  input  logic iclk,
  input  logic ireset,
  input  logic isig,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], isig};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures high-phase width and period of a slow clock in iclk cycles.
// Define CLOCK_METER_CONTINUOUS_EN to post a result every isig period after one istart.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter logic [31:0] TIMEOUT     = DEF_TIMEOUT,
  parameter int          SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 isig,
  clock_period_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] ohigh_q, ohigh_d;
  logic [CNT_W-1:0] operiod_q, operiod_d;
  logic             otimeout_q, otimeout_d;
  logic [31:0]      tmo_q, tmo_d;

  logic             rise, fall, edge_seen, tmo_hit;
  logic [CNT_W-1:0] cnt_inc, period_sat;
  logic [CNT_W:0]   period_sum;

  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .iclk   (iclk),
    .ireset (ireset),
    .isig   (isig),
    .rise   (rise),
    .fall   (fall)
  );

  // Any strobe restarts the timeout window, so an edge always beats the terminal count.
  assign edge_seen  = rise | fall;
  assign tmo_hit    = (tmo_q == TIMEOUT - 32'd1) && !edge_seen;
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign period_sum = {1'b0, high_q} + {1'b0, cnt_q};
  assign period_sat = period_sum[CNT_W] ? CNT_MAX : period_sum[CNT_W-1:0];

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_q     <= '0;
      ohigh_q    <= '0;
      operiod_q  <= '0;
      otimeout_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_q     <= high_d;
      ohigh_q    <= ohigh_d;
      operiod_q  <= operiod_d;
      otimeout_q <= otimeout_d;
      tmo_q      <= tmo_d;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_d     = high_q;
    ohigh_d    = ohigh_q;
    operiod_d  = operiod_q;
    otimeout_d = otimeout_q;
    tmo_d      = tmo_q;

    if (state_q == ARM || state_q == MEAS_HIGH || state_q == MEAS_LOW) begin
      tmo_d = edge_seen ? '0 : tmo_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.istart) begin
          state_d    = ARM;
          otimeout_d = 1'b0;
          tmo_d      = '0;
        end
      end

      ARM: begin
        if (rise) begin
          state_d = MEAS_HIGH;
          cnt_d   = CNT_ONE;
        end else if (tmo_hit) begin
          state_d    = DONE;
          ohigh_d    = '0;
          operiod_d  = '0;
          otimeout_d = 1'b1;
        end
      end

      MEAS_HIGH: begin
        cnt_d = cnt_inc;
        if (fall) begin
          high_d  = cnt_q;
          cnt_d   = CNT_ONE;
          state_d = MEAS_LOW;
        end else if (tmo_hit) begin
          state_d    = DONE;
          ohigh_d    = '0;
          operiod_d  = '0;
          otimeout_d = 1'b1;
        end
      end

      MEAS_LOW: begin
        cnt_d = cnt_inc;
        if (rise) begin
          ohigh_d    = high_q;
          operiod_d  = period_sat;
          otimeout_d = 1'b0;
          cnt_d      = CNT_ONE;
          state_d    = DONE;
        end else if (tmo_hit) begin
          state_d    = DONE;
          ohigh_d    = '0;
          operiod_d  = '0;
          otimeout_d = 1'b1;
        end
      end

      DONE: begin
`ifdef CLOCK_METER_CONTINUOUS_EN
        // The closing rise opens the next period; cnt keeps counting through this cycle.
        if (otimeout_q) begin
          state_d = ARM;
          tmo_d   = '0;
        end else begin
          state_d = MEAS_HIGH;
          cnt_d   = cnt_inc;
          tmo_d   = fall ? '0 : tmo_q + 32'd1;
          if (fall) begin
            high_d  = cnt_q;
            cnt_d   = CNT_ONE;
            state_d = MEAS_LOW;
          end
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef CLOCK_METER_CONTINUOUS_EN
  assign bus.obusy = (state_q != IDLE);
`else
  assign bus.obusy = (state_q == ARM) || (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);
`endif
  assign bus.ovalid   = (state_q == DONE);
  assign bus.otimeout = otimeout_q;
  assign bus.ohigh    = ohigh_q;
  assign bus.operiod  = operiod_q;

endmodule
